// File: rtl/ord_id_issuer.sv
// Transaction-ID issuer for the reorder buffer: tags master read requests with a
// round-robin ID that still has credit and forks each tagged request to the slave and order ports.
module ord_id_issuer #(
  parameter int ORD_DEPTH = 4,
  parameter int ID_W      = $clog2(ORD_DEPTH),
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_OUTST = 4,
  localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LEN_W-1:0]             req_len,
  input  logic                         req_vld,
  output logic                         req_rdy,
  output logic [ID_W-1:0]              iss_id,
  output logic [ADDR_W-1:0]            iss_addr,
  output logic [LEN_W-1:0]             iss_len,
  output logic                         iss_vld,
  input  logic                         iss_rdy,
  output logic [ID_W-1:0]              ord_id,
  output logic [LEN_W-1:0]             ord_len,
  output logic                         ord_vld,
  input  logic                         ord_rdy,
  input  logic [ID_W-1:0]              cpl_id,
  input  logic                         cpl_last,
  input  logic                         cpl_vld,
  output logic [ORD_DEPTH*CNT_W-1:0]   outst_cnt_o,
  output logic                         cpl_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(ORD_DEPTH - 1);

  logic [ORD_DEPTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                            iss_pend_q, iss_pend_d;
  logic                            ord_pend_q, ord_pend_d;
  logic [ID_W-1:0]                 slot_id_q, slot_id_d;
  logic [ADDR_W-1:0]               slot_addr_q, slot_addr_d;
  logic [LEN_W-1:0]                slot_len_q, slot_len_d;
  logic                            cpl_err_q, cpl_err_d;

  logic                            avail;
  logic [ID_W-1:0]                 cand_id;
  logic [ID_W-1:0]                 probe;
  logic                            iss_hs, ord_hs;
  logic                            slot_open;
  logic                            accept;
  logic                            cpl_fire;
  logic                            cpl_oor;
  logic                            inc, dec_ok;

  // Candidate: first ID at or after rr_ptr (wrapping) that still has credit.
  always_comb begin
    avail   = 1'b0;
    cand_id = '0;
    probe   = '0;
    for (int i = 0; i < ORD_DEPTH; i++) begin
      probe = ID_W'((int'(rr_ptr_q) + i) % ORD_DEPTH);
      if (!avail && (cnt_q[probe] < MAX_CNT)) begin
        avail   = 1'b1;
        cand_id = probe;
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Valid never drops and slot data never changes until that transfer; ready may
  // depend combinationally on the sink, so req_rdy follows iss_rdy/ord_rdy in-cycle.
  assign iss_hs    = iss_pend_q & iss_rdy;
  assign ord_hs    = ord_pend_q & ord_rdy;
  assign slot_open = (~iss_pend_q | iss_hs) & (~ord_pend_q | ord_hs);
  assign req_rdy   = avail & slot_open;
  assign accept    = req_vld & req_rdy;

  always_comb begin
    iss_pend_d  = iss_pend_q & ~iss_hs;
    ord_pend_d  = ord_pend_q & ~ord_hs;
    slot_id_d   = slot_id_q;
    slot_addr_d = slot_addr_q;
    slot_len_d  = slot_len_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      iss_pend_d  = 1'b1;
      ord_pend_d  = 1'b1;
      slot_id_d   = cand_id;
      slot_addr_d = req_addr;
      slot_len_d  = req_len;
      rr_ptr_d    = (cand_id == LAST_ID) ? '0 : cand_id + ID_W'(1);
    end
  end

  assign cpl_fire = cpl_vld & cpl_last;
  assign cpl_oor  = ({1'b0, cpl_id} >= (ID_W + 1)'(ORD_DEPTH));

  // Credit counters; a completion on an empty ID saturates at zero and flags an error.
  always_comb begin
    cnt_d     = cnt_q;
    cpl_err_d = cpl_err_q;
    inc       = 1'b0;
    dec_ok    = 1'b0;
    if (cpl_fire && cpl_oor) begin
      cpl_err_d = 1'b1;
    end
    for (int i = 0; i < ORD_DEPTH; i++) begin
      inc    = accept && (cand_id == ID_W'(i));
      dec_ok = 1'b0;
      if (cpl_fire && !cpl_oor && (cpl_id == ID_W'(i))) begin
        if (cnt_q[i] == '0) begin
          cpl_err_d = 1'b1;
        end else begin
          dec_ok = 1'b1;
        end
      end
      if (inc && !dec_ok) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!inc && dec_ok) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      iss_pend_q  <= 1'b0;
      ord_pend_q  <= 1'b0;
      slot_id_q   <= '0;
      slot_addr_q <= '0;
      slot_len_q  <= '0;
      cpl_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      iss_pend_q  <= iss_pend_d;
      ord_pend_q  <= ord_pend_d;
      slot_id_q   <= slot_id_d;
      slot_addr_q <= slot_addr_d;
      slot_len_q  <= slot_len_d;
      cpl_err_q   <= cpl_err_d;
    end
  end

  assign iss_vld     = iss_pend_q;
  assign iss_id      = slot_id_q;
  assign iss_addr    = slot_addr_q;
  assign iss_len     = slot_len_q;
  assign ord_vld     = ord_pend_q;
  assign ord_id      = slot_id_q;
  assign ord_len     = slot_len_q;
  assign outst_cnt_o = cnt_q;
  assign cpl_err     = cpl_err_q;

endmodule
